mem_arbiter: RTL and testbench

Shares the single unified memory port between the NPC instruction-fetch path and the load/store path, replacing their separate Imem/Dmem connections once the core moves to one physical memory. It accepts one request at a time from either requester, forwards it to memory with a valid/ready handshake, waits for the response, and routes the response back to the owner. Load/store has priority; an age counter guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_age_cnt.sv | 32 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the unified-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  // Transaction phase: accepting, presenting the request, awaiting the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Which requester owns the outstanding transaction.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // RISC-V funct3 for a 32-bit word load; every fetch is issued as one.
  localparam logic [2:0] WOP_LW = 3'b010;

endpackage

// File: rtl/mem_arb_age_cnt.sv
// Purpose: saturating counter of consecutive fetch losses against load/store.
// Latency: count and sat update one cycle after inc/clr.
// Backpressure: none; counts whenever inc is high, clr has priority over inc.
//
// Ports: clk, rst (async active-low), inc, clr, sat (count == MAX).
module mem_arb_age_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != MAX_C)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between instruction fetch and load/store.
// Latency: accept -> mem request next cycle; response pulse one cycle after mem_rsp_valid (min 3).
// Backpressure: one transaction outstanding; requester readies only in IDLE, mem_req held until mem_req_ready.
//
// Ports:
//   clk, rst (async active-low)
//   if_req_valid/if_req_ready/if_addr, if_rsp_valid/if_rdata        : fetch side
//   ls_req_valid/ls_req_ready/ls_addr/ls_wen/ls_wop/ls_wdata,
//   ls_rsp_valid/ls_rdata                                            : load/store side
//   mem_req_valid/mem_req_ready/mem_addr/mem_wen/mem_wop/mem_wdata,
//   mem_rsp_valid/mem_rdata                                          : unified memory port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_IF_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [2:0]        ls_wop,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [2:0]        mem_wop,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  owner_t owner;

  logic idle;
  logic if_win;
  logic ls_win;
  logic age_sat;
  logic age_inc;
  logic age_clr;

  assign idle = (state == IDLE);

  // Load/store wins by default; a starved fetch wins once it has lost
  // MAX_IF_WAIT consecutive contested rounds.
  assign if_win = if_req_valid && (!ls_req_valid || age_sat);
  assign ls_win = ls_req_valid && !if_win;

  // Gated by rst so both readies read 0 while reset is held.
  assign if_req_ready = rst && idle && if_win;
  assign ls_req_ready = rst && idle && ls_win;

  // Only a contested round that fetch loses ages it.
  assign age_inc = if_req_valid && ls_req_ready;
  assign age_clr = if_req_ready;

  mem_arb_age_cnt #(
    .MAX (MAX_IF_WAIT)
  ) u_age_cnt (
    .clk (clk),
    .rst (rst),
    .inc (age_inc),
    .clr (age_clr),
    .sat (age_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wop       <= 3'b000;
      mem_wdata     <= '0;
      if_rsp_valid  <= 1'b0;
      if_rdata      <= '0;
      ls_rsp_valid  <= 1'b0;
      ls_rdata      <= '0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ls_req_ready) begin
            owner         <= OWN_LS;
            mem_addr      <= ls_addr;
            mem_wen       <= ls_wen;
            mem_wop       <= ls_wop;
            mem_wdata     <= ls_wdata;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end else if (if_req_ready) begin
            owner         <= OWN_IF;
            mem_addr      <= if_addr;
            mem_wen       <= 1'b0;
            mem_wop       <= WOP_LW;
            mem_wdata     <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end

        // A response seen here is not ours yet; only the request handshake counts.
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end

        WAIT: begin
          if (mem_rsp_valid) begin
            if (owner == OWN_LS) begin
              ls_rdata     <= mem_wen ? '0 : mem_rdata;
              ls_rsp_valid <= 1'b1;
            end else begin
              if_rdata     <= mem_rdata;
              if_rsp_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end

        default: begin
          mem_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: memory ready/response driven directly by the stimulus steps.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_addr;
  logic        ls_wen;
  logic [2:0]  ls_wop;
  logic [31:0] ls_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [2:0]  mem_wop;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic        exp_if;
  logic        prev_if;
  logic [31:0] exp_tag;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_IF_WAIT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_rsp_valid  (if_rsp_valid),
    .if_rdata      (if_rdata),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_addr       (ls_addr),
    .ls_wen        (ls_wen),
    .ls_wop        (ls_wop),
    .ls_wdata      (ls_wdata),
    .ls_rsp_valid  (ls_rsp_valid),
    .ls_rdata      (ls_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wop       (mem_wop),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    if_req_valid  = 1'b1;   // requester valid during reset must not see ready
    if_addr       = 32'h0;
    ls_req_valid  = 1'b0;
    ls_addr       = 32'h0;
    ls_wen        = 1'b0;
    ls_wop        = 3'b000;
    ls_wdata      = 32'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0;
    prev_if       = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    smp;
    chk1 ("rst_if_rsp",   if_rsp_valid,  1'b0);
    chk1 ("rst_ls_rsp",   ls_rsp_valid,  1'b0);
    chk1 ("rst_mem_req",  mem_req_valid, 1'b0);
    chk32("rst_if_rdata", if_rdata,      32'h0);
    chk32("rst_ls_rdata", ls_rdata,      32'h0);
    chk32("rst_mem_addr", mem_addr,      32'h0);
    chk1 ("rst_if_rdy",   if_req_ready,  1'b0);
    nxt;
    rst = 1'b1;
    if_req_valid = 1'b0;
    nxt;

    // ---------------- single fetch ----------------
    if_req_valid = 1'b1; if_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    smp;
    chk1("t1_if_rdy",  if_req_ready,  1'b1);
    chk1("t1_ls_rdy",  ls_req_ready,  1'b0);
    chk1("t1_mreq_c0", mem_req_valid, 1'b0);
    nxt;
    if_req_valid = 1'b0;
    smp;
    chk1 ("t1_mreq_c1", mem_req_valid, 1'b1);
    chk32("t1_maddr",   mem_addr,  32'h8000_0000);
    chk1 ("t1_mwen",    mem_wen,   1'b0);
    chk32("t1_mwop",    {29'b0, mem_wop}, 32'd2);
    chk32("t1_mwdata",  mem_wdata, 32'h0);
    nxt;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
    smp;
    chk1("t1_mreq_c2",  mem_req_valid, 1'b0);
    chk1("t1_rsp_c2",   if_rsp_valid,  1'b0);
    nxt;
    mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    smp;
    chk1 ("t1_rsp_c3",    if_rsp_valid, 1'b1);
    chk32("t1_rdata",     if_rdata,     32'h0010_0073);
    chk1 ("t1_ls_rsp_c3", ls_rsp_valid, 1'b0);
    nxt;
    smp;
    chk1 ("t1_rsp_c4",    if_rsp_valid, 1'b0);
    chk32("t1_rdata_hold", if_rdata,    32'h0010_0073);
    nxt;

    // ---------------- store with 5-cycle memory stall ----------------
    ls_req_valid = 1'b1; ls_addr = 32'h8000_0100; ls_wen = 1'b1;
    ls_wop = 3'b010; ls_wdata = 32'hDEAD_BEEF; mem_req_ready = 1'b0;
    smp;
    chk1("t2_ls_rdy", ls_req_ready, 1'b1);
    chk1("t2_if_rdy", if_req_ready, 1'b0);
    nxt;
    // both requesters pushing with different fields while the request is pending
    if_req_valid = 1'b1; ls_req_valid = 1'b1;
    ls_addr = 32'h1111_1110; ls_wen = 1'b0; ls_wop = 3'b101; ls_wdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      smp;
      chk1 ("t2_stall_mreq",  mem_req_valid, 1'b1);
      chk32("t2_stall_addr",  mem_addr,  32'h8000_0100);
      chk1 ("t2_stall_wen",   mem_wen,   1'b1);
      chk32("t2_stall_wop",   {29'b0, mem_wop}, 32'd2);
      chk32("t2_stall_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1 ("t2_stall_ifrdy", if_req_ready, 1'b0);
      chk1 ("t2_stall_lsrdy", ls_req_ready, 1'b0);
      nxt;
    end
    mem_req_ready = 1'b1;
    smp;
    chk1 ("t2_hs_mreq", mem_req_valid, 1'b1);
    chk32("t2_hs_addr", mem_addr, 32'h8000_0100);
    nxt;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    smp;
    chk1("t2_wait_ifrdy", if_req_ready,  1'b0);
    chk1("t2_wait_lsrdy", ls_req_ready,  1'b0);
    chk1("t2_wait_mreq",  mem_req_valid, 1'b0);
    nxt;
    mem_rsp_valid = 1'b0; if_req_valid = 1'b0; ls_req_valid = 1'b0;
    smp;
    chk1 ("t2_ls_rsp",    ls_rsp_valid, 1'b1);
    chk32("t2_ls_rdata",  ls_rdata,     32'h0);
    chk1 ("t2_if_rsp",    if_rsp_valid, 1'b0);
    chk32("t2_if_rdata",  if_rdata,     32'h0010_0073);
    nxt;

    // ---------------- contention: LS x4 then IF, repeating ----------------
    if_req_valid = 1'b1; if_addr = 32'h0000_1000;
    ls_req_valid = 1'b1; ls_addr = 32'h0000_2000; ls_wen = 1'b0;
    ls_wop = 3'b000; ls_wdata = 32'h0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;   // response also high in IDLE/REQ
    for (int i = 0; i < 10; i++) begin
      exp_if = ((i % 5) == 4);
      mem_rdata = 32'hBAD0_0000 + 32'(i);
      smp;
      if (i > 0) begin
        exp_tag = 32'hC0DE_0000 + 32'(i - 1);
        chk1("t3_if_pulse", if_rsp_valid, prev_if);
        chk1("t3_ls_pulse", ls_rsp_valid, !prev_if);
        if (prev_if) chk32("t3_if_rdata", if_rdata, exp_tag);
        else         chk32("t3_ls_rdata", ls_rdata, exp_tag);
      end
      chk1("t3_grant_if", if_req_ready, exp_if);
      chk1("t3_grant_ls", ls_req_ready, !exp_if);
      nxt;
      mem_rdata = 32'hBAD1_0000 + 32'(i);
      smp;
      chk1 ("t3_mreq", mem_req_valid, 1'b1);
      chk32("t3_addr", mem_addr, exp_if ? 32'h0000_1000 : 32'h0000_2000);
      chk32("t3_wop",  {29'b0, mem_wop}, exp_if ? 32'd2 : 32'd0);
      nxt;
      mem_rdata = 32'hC0DE_0000 + 32'(i);
      smp;
      chk1("t3_wait_ifrdy", if_req_ready, 1'b0);
      chk1("t3_wait_lsrdy", ls_req_ready, 1'b0);
      nxt;
      prev_if = exp_if;
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    smp;
    chk1 ("t3_last_if_pulse", if_rsp_valid, 1'b1);
    chk32("t3_last_if_rdata", if_rdata, 32'hC0DE_0009);
    nxt;

    // ---------------- spurious responses in IDLE and REQ ----------------
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      smp;
      chk1("t4_idle_if_rsp", if_rsp_valid,  1'b0);
      chk1("t4_idle_ls_rsp", ls_rsp_valid,  1'b0);
      chk1("t4_idle_mreq",   mem_req_valid, 1'b0);
      nxt;
    end
    if_req_valid = 1'b1; if_addr = 32'h8000_0004;
    smp;
    chk1("t4_if_rdy", if_req_ready, 1'b1);
    nxt;
    if_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp;
      chk1 ("t4_req_mreq",   mem_req_valid, 1'b1);
      chk1 ("t4_req_if_rsp", if_rsp_valid,  1'b0);
      chk32("t4_req_addr",   mem_addr, 32'h8000_0004);
      nxt;
    end
    mem_req_ready = 1'b1;   // ready and response together in REQ
    smp;
    chk1("t4_hs_mreq", mem_req_valid, 1'b1);
    nxt;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    smp;
    chk1 ("t4_wait_if_rsp", if_rsp_valid, 1'b0);
    chk32("t4_wait_rdata",  if_rdata, 32'hC0DE_0009);
    nxt;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0013;
    smp;
    chk1("t4_wait2_if_rsp", if_rsp_valid, 1'b0);
    nxt;
    mem_rsp_valid = 1'b0;
    smp;
    chk1 ("t4_if_rsp",   if_rsp_valid, 1'b1);
    chk32("t4_if_rdata", if_rdata, 32'h0000_0013);
    nxt;

    // ---------------- reset during WAIT ----------------
    if_req_valid = 1'b1; if_addr = 32'h8000_0008; mem_req_ready = 1'b1;
    smp;
    nxt;
    if_req_valid = 1'b0;
    smp;
    chk1("t5_mreq", mem_req_valid, 1'b1);
    nxt;
    mem_req_ready = 1'b0;
    smp;
    chk1("t5_wait_mreq", mem_req_valid, 1'b0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h9999_9999;
    #1;
    chk32("t5_rst_if_rdata", if_rdata,      32'h0);
    chk32("t5_rst_ls_rdata", ls_rdata,      32'h0);
    chk1 ("t5_rst_if_rsp",   if_rsp_valid,  1'b0);
    chk1 ("t5_rst_mreq",     mem_req_valid, 1'b0);
    chk32("t5_rst_maddr",    mem_addr,      32'h0);
    nxt;
    rst = 1'b1;
    smp;
    chk1("t5_post_if_rsp", if_rsp_valid,  1'b0);
    chk1("t5_post_ls_rsp", ls_rsp_valid,  1'b0);
    chk1("t5_post_mreq",   mem_req_valid, 1'b0);
    nxt;
    mem_rsp_valid = 1'b0;
    smp;
    chk1 ("t5_post2_if_rsp", if_rsp_valid, 1'b0);
    chk32("t5_post2_rdata",  if_rdata, 32'h0);
    nxt;
    if_req_valid = 1'b1; if_addr = 32'h8000_000C; mem_req_ready = 1'b1;
    smp;
    chk1("t5_if_rdy", if_req_ready, 1'b1);
    nxt;
    if_req_valid = 1'b0;
    smp;
    chk32("t5_addr", mem_addr, 32'h8000_000C);
    nxt;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0073;
    smp;
    nxt;
    mem_rsp_valid = 1'b0;
    smp;
    chk1 ("t5_if_rsp",   if_rsp_valid, 1'b1);
    chk32("t5_if_rdata", if_rdata, 32'h0000_0073);
    nxt;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
